// File: rtl/fifo_credit_pkg.sv
// Shared types and helpers for the credit-based sender: state encoding,
// counter-width derivation and the saturating credit update.
package fifo_credit_pkg;

    typedef enum logic [0:0] {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } credit_state_e;

    function automatic int calc_count_width(input int max_credit);
        return (max_credit < 1) ? 1 : $clog2(max_credit + 1);
    endfunction

    // One step of +1/-1 credit movement, clamped to [0, max_value].
    function automatic int unsigned sat_add_sub(
        input int unsigned value,
        input logic        incr,
        input logic        decr,
        input int unsigned max_value
    );
        int unsigned res_v;
        if (incr && !decr) begin
            res_v = (value >= max_value) ? max_value : value + 32'd1;
        end else if (decr && !incr) begin
            res_v = (value == 32'd0) ? 32'd0 : value - 32'd1;
        end else begin
            res_v = value;
        end
        return res_v;
    endfunction

    function automatic logic sat_overflow(
        input int unsigned value,
        input logic        incr,
        input logic        decr,
        input int unsigned max_value
    );
        return incr && !decr && (value >= max_value);
    endfunction

endpackage

// File: rtl/fifo_credit_counter.sv
// Credit bookkeeping: INIT/ACTIVE state, clamped initial load, saturating
// count with sticky overflow, and the spendable-credit computation.
module fifo_credit_counter
    import fifo_credit_pkg::*;
#(
    parameter int MaxCredit  = 12,
    parameter int CountWidth = calc_count_width(MaxCredit)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CountWidth-1:0] credit_initial,
    input  logic [CountWidth-1:0] credit_withhold,
    input  logic                  decr,
    input  logic                  incr,
    output logic                  active,
    output logic [CountWidth-1:0] credit_count,
    output logic [CountWidth-1:0] credit_available,
    output logic                  credit_overflow
);

    localparam logic [CountWidth-1:0] MAX_COUNT = CountWidth'(MaxCredit);

    credit_state_e         state_r, state_nxt_s;
    logic [CountWidth-1:0] count_r, count_nxt_s;
    logic                  ovf_r, ovf_nxt_s;
    logic [CountWidth-1:0] init_clamped_s;
    logic [CountWidth-1:0] avail_s;

    // Clamp the configured initial credit to the remote FIFO depth.
    always_comb begin
        if (credit_initial > MAX_COUNT) begin
            init_clamped_s = MAX_COUNT;
        end else begin
            init_clamped_s = credit_initial;
        end
    end

    // State, counter and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            count_r <= {CountWidth{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Next-state logic; credits returned while still in INIT are dropped.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        ovf_nxt_s   = ovf_r;
        case (state_r)
            ST_INIT: begin
                state_nxt_s = ST_ACTIVE;
                count_nxt_s = init_clamped_s;
            end
            ST_ACTIVE: begin
                count_nxt_s = CountWidth'(sat_add_sub(32'(count_r), incr, decr, 32'(MaxCredit)));
                ovf_nxt_s   = ovf_r | sat_overflow(32'(count_r), incr, decr, 32'(MaxCredit));
            end
            default: begin
                state_nxt_s = ST_INIT;
                count_nxt_s = {CountWidth{1'b0}};
                ovf_nxt_s   = ovf_r;
            end
        endcase
    end

    // Spendable credits: count minus reserve, floored at zero.
    always_comb begin
        if ((state_r == ST_ACTIVE) && (count_r > credit_withhold)) begin
            avail_s = count_r - credit_withhold;
        end else begin
            avail_s = {CountWidth{1'b0}};
        end
    end

    assign active           = (state_r == ST_ACTIVE);
    assign credit_count     = count_r;
    assign credit_available = avail_s;
    assign credit_overflow  = ovf_r;

endmodule

// File: rtl/fifo_credit_sender.sv
// Transmit endpoint of a credit link: gates push_ready on spendable credit
// and forwards beats. FIFO_CREDIT_SENDER_REG_OUT_EN registers tx_valid/tx_data.
module fifo_credit_sender
    import fifo_credit_pkg::*;
#(
    parameter int Width      = 8,
    parameter int MaxCredit  = 12,
    parameter int CountWidth = calc_count_width(MaxCredit)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  push_ready,
    input  logic                  push_valid,
    input  logic [Width-1:0]      push_data,
    input  logic [CountWidth-1:0] credit_initial,
    input  logic [CountWidth-1:0] credit_withhold,
    input  logic                  push_credit_stall,
    input  logic                  pop_credit,
    output logic                  tx_valid,
    output logic [Width-1:0]      tx_data,
    output logic [CountWidth-1:0] credit_count,
    output logic [CountWidth-1:0] credit_available,
    output logic                  credit_overflow
);

    logic active_s;
    logic push_ready_s;
    logic push_beat_s;

    fifo_credit_counter #(
        .MaxCredit  (MaxCredit),
        .CountWidth (CountWidth)
    ) u_counter (
        .clk              (clk),
        .rst_n            (rst_n),
        .credit_initial   (credit_initial),
        .credit_withhold  (credit_withhold),
        .decr             (push_beat_s),
        .incr             (pop_credit),
        .active           (active_s),
        .credit_count     (credit_count),
        .credit_available (credit_available),
        .credit_overflow  (credit_overflow)
    );

    // Ready depends only on registered credit state, never on push_valid.
    assign push_ready_s = active_s & ~push_credit_stall & (credit_available != {CountWidth{1'b0}});
    assign push_beat_s  = push_valid & push_ready_s;
    assign push_ready   = push_ready_s;

`ifdef FIFO_CREDIT_SENDER_REG_OUT_EN
    logic             tx_valid_r;
    logic [Width-1:0] tx_data_r;

    // Output stage for long downstream wires; credit is still spent at push time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= {Width{1'b0}};
        end else begin
            tx_valid_r <= push_beat_s;
            if (push_beat_s) begin
                tx_data_r <= push_data;
            end else begin
                tx_data_r <= tx_data_r;
            end
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
`else
    assign tx_valid = push_beat_s;
    assign tx_data  = push_data;
`endif

endmodule

// File: tb/tb_fifo_credit_sender.sv
// Directed bench for fifo_credit_sender with a data scoreboard on tx beats.
module tb_fifo_credit_sender;

    localparam int W  = 8;
    localparam int MC = 12;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          push_ready;
    logic          push_valid;
    logic [W-1:0]  push_data;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic          push_credit_stall;
    logic          pop_credit;
    logic          tx_valid;
    logic [W-1:0]  tx_data;
    logic [CW-1:0] credit_count;
    logic [CW-1:0] credit_available;
    logic          credit_overflow;

    int n_cmp    = 0;
    int n_fail   = 0;
    int tx_beats = 0;
    logic [W-1:0] sb_q[$];

    fifo_credit_sender #(.Width(W), .MaxCredit(MC), .CountWidth(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .push_ready        (push_ready),
        .push_valid        (push_valid),
        .push_data         (push_data),
        .credit_initial    (credit_initial),
        .credit_withhold   (credit_withhold),
        .push_credit_stall (push_credit_stall),
        .pop_credit        (pop_credit),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .credit_count      (credit_count),
        .credit_available  (credit_available),
        .credit_overflow   (credit_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every tx beat must match the oldest expected push.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && tx_valid === 1'b1) begin
            tx_beats++;
            if (sb_q.size() == 0) begin
                chk("tx_unexpected", 32'd1, 32'd0);
            end else begin
                chk("tx_data", 32'(tx_data), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n = 1'b0; push_valid = 1'b0; push_data = 8'h00;
        credit_initial = 4'd12; credit_withhold = 4'd0;
        push_credit_stall = 1'b0; pop_credit = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(push_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_count", 32'(credit_count), 32'd0);
        chk("rst_ovf", 32'(credit_overflow), 32'd0);
        chk("rst_avail", 32'(credit_available), 32'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("init_ready", 32'(push_ready), 32'd0);
        chk("init_avail", 32'(credit_available), 32'd0);
        step();
        @(negedge clk);
        chk("act_count", 32'(credit_count), 32'd12);
        chk("act_avail", 32'(credit_available), 32'd12);
        step();

        // Drain all 12 credits with push_valid held high
        push_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_data = 8'h10 + 8'(i);
            sb_q.push_back(push_data);
            @(negedge clk);
            chk("t1_ready", 32'(push_ready), 32'd1);
            chk("t1_count", 32'(credit_count), 32'(12 - i));
            step();
        end
        push_data = 8'hEE;
        @(negedge clk);
        chk("t1_ready_empty", 32'(push_ready), 32'd0);
        chk("t1_count_empty", 32'(credit_count), 32'd0);
        chk("t1_avail_empty", 32'(credit_available), 32'd0);
        step();
        chk("t1_beats", 32'(tx_beats), 32'd12);

        // Returned credit is spendable only the next cycle
        pop_credit = 1'b1;
        @(negedge clk);
        chk("t2_ready_same", 32'(push_ready), 32'd0);
        step();
        pop_credit = 1'b0;
        push_data = 8'h3C;
        sb_q.push_back(push_data);
        @(negedge clk);
        chk("t2_ready_next", 32'(push_ready), 32'd1);
        chk("t2_count", 32'(credit_count), 32'd1);
        step();
        @(negedge clk);
        chk("t2_ready_after", 32'(push_ready), 32'd0);
        chk("t2_count_after", 32'(credit_count), 32'd0);
        push_valid = 1'b0;
        step();
        chk("t2_beats", 32'(tx_beats), 32'd13);

        // Simultaneous beat and credit return at count=5
        pop_credit = 1'b1;
        repeat (5) step();
        pop_credit = 1'b0;
        @(negedge clk);
        chk("t3_count5", 32'(credit_count), 32'd5);
        step();
        push_valid = 1'b1; pop_credit = 1'b1; push_data = 8'h5A;
        sb_q.push_back(push_data);
        @(negedge clk);
        chk("t3_ready", 32'(push_ready), 32'd1);
`ifndef FIFO_CREDIT_SENDER_REG_OUT_EN
        chk("t3_tx_valid", 32'(tx_valid), 32'd1);
`endif
        step();
        push_valid = 1'b0; pop_credit = 1'b0;
        @(negedge clk);
        chk("t3_count_same", 32'(credit_count), 32'd5);

        // Withhold limits spendable credit
        step();
        credit_withhold = 4'd3;
        @(negedge clk);
        chk("t4_avail2", 32'(credit_available), 32'd2);
        step();
        push_valid = 1'b1; push_data = 8'hA0; sb_q.push_back(push_data);
        @(negedge clk);
        chk("t4_ready_a", 32'(push_ready), 32'd1);
        step();
        push_data = 8'hA1; sb_q.push_back(push_data);
        @(negedge clk);
        chk("t4_avail1", 32'(credit_available), 32'd1);
        chk("t4_ready_b", 32'(push_ready), 32'd1);
        step();
        push_data = 8'hA2;
        @(negedge clk);
        chk("t4_ready_c", 32'(push_ready), 32'd0);
        chk("t4_count3", 32'(credit_count), 32'd3);
        step();
        push_valid = 1'b0; credit_withhold = 4'd5;
        @(negedge clk);
        chk("t4_wh5_ready", 32'(push_ready), 32'd0);
        chk("t4_wh5_avail", 32'(credit_available), 32'd0);
        step();
        credit_withhold = 4'd1;
        @(negedge clk);
        chk("t4_reopen_ready", 32'(push_ready), 32'd1);
        chk("t4_reopen_avail", 32'(credit_available), 32'd2);
        step();
        credit_withhold = 4'd0; push_credit_stall = 1'b1;
        @(negedge clk);
        chk("t4_stall_ready", 32'(push_ready), 32'd0);
        chk("t4_stall_avail", 32'(credit_available), 32'd3);
        step();
        push_credit_stall = 1'b0;
        chk("t4_beats", 32'(tx_beats), 32'd16);

        // Saturation and sticky overflow
        pop_credit = 1'b1;
        repeat (9) step();
        pop_credit = 1'b0;
        @(negedge clk);
        chk("t5_count12", 32'(credit_count), 32'd12);
        chk("t5_ovf_pre", 32'(credit_overflow), 32'd0);
        step();
        pop_credit = 1'b1;
        step();
        pop_credit = 1'b0;
        @(negedge clk);
        chk("t5_count_sat", 32'(credit_count), 32'd12);
        chk("t5_ovf_set", 32'(credit_overflow), 32'd1);
        step();
        push_valid = 1'b1; push_data = 8'h77; sb_q.push_back(push_data);
        @(negedge clk);
        chk("t5_ready", 32'(push_ready), 32'd1);
        step();
        push_valid = 1'b0;
        @(negedge clk);
        chk("t5_count11", 32'(credit_count), 32'd11);
        chk("t5_ovf_sticky", 32'(credit_overflow), 32'd1);

        // Reset mid-stream clears everything at once
        step();
        push_valid = 1'b1; push_data = 8'h88; credit_initial = 4'd7;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", 32'(push_ready), 32'd0);
        chk("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("t5_rst_count", 32'(credit_count), 32'd0);
        chk("t5_rst_avail", 32'(credit_available), 32'd0);
        chk("t5_rst_ovf", 32'(credit_overflow), 32'd0);
        step();
        rst_n = 1'b1; push_valid = 1'b0; pop_credit = 1'b1;
        @(negedge clk);
        chk("t5_init_ready", 32'(push_ready), 32'd0);
        step();
        pop_credit = 1'b0;
        @(negedge clk);
        chk("t5_reload7", 32'(credit_count), 32'd7);
        chk("t5_reload_ovf", 32'(credit_overflow), 32'd0);

        // Initial credit above depth is clamped
        step();
        rst_n = 1'b0; credit_initial = 4'd15;
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("t5_clamp12", 32'(credit_count), 32'd12);

        // Beat timing of tx outputs
        step();
        push_valid = 1'b1; push_data = 8'hA5; sb_q.push_back(push_data);
        @(negedge clk);
`ifdef FIFO_CREDIT_SENDER_REG_OUT_EN
        chk("t6_tx_valid_n", 32'(tx_valid), 32'd0);
`else
        chk("t6_tx_valid_n", 32'(tx_valid), 32'd1);
        chk("t6_tx_data_n", 32'(tx_data), 32'hA5);
`endif
        step();
        push_valid = 1'b0; push_data = 8'h00;
        @(negedge clk);
`ifdef FIFO_CREDIT_SENDER_REG_OUT_EN
        chk("t6_tx_valid_n1", 32'(tx_valid), 32'd1);
        chk("t6_tx_data_n1", 32'(tx_data), 32'hA5);
`else
        chk("t6_tx_valid_n1", 32'(tx_valid), 32'd0);
`endif
        chk("t6_count11", 32'(credit_count), 32'd11);

        repeat (3) step();
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("total_beats", 32'(tx_beats), 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_credit_sender.md
Name: fifo_credit_sender

Overview:
- Transmit-side endpoint of a credit-based link. It turns a local valid/ready push interface into a credit-gated valid-only stream toward a remote flop FIFO, which returns one credit per popped entry.
- Maintains a saturating credit counter and gates upstream push_ready on credit availability.
- Sits ahead of long or registered wires where ready cannot be routed back combinationally.

Parameters:
- Width, 8, data width in bits.
- MaxCredit, 12, maximum credits; equals the remote FIFO depth.
- CountWidth, $clog2(MaxCredit+1), credit counter width (4 at default).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- push_ready  out  1  upstream ready.
- push_valid  in  1  upstream valid.
- push_data  in  Width  upstream data.
- credit_initial  in  CountWidth  credit count loaded on leaving INIT; must be stable while rst_n is low.
- credit_withhold  in  CountWidth  credits reserved and not spendable; dynamic.
- push_credit_stall  in  1  when high, forces push_ready low.
- pop_credit  in  1  one credit returned from the receiver this cycle.
- tx_valid  out  1  downstream beat valid; no backpressure.
- tx_data  out  Width  downstream data.
- credit_count  out  CountWidth  current credit counter value.
- credit_available  out  CountWidth  spendable credits.
- credit_overflow  out  1  sticky error flag.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - state=INIT, credit_count=0, credit_overflow=0.
  - tx_valid=0, tx_data=0, push_ready=0.
- State machine, 2 states:
  - INIT -> ACTIVE on the first clk edge with rst_n high. That edge loads credit_count=min(credit_initial, MaxCredit).
  - ACTIVE is held until reset. pop_credit in INIT is dropped.
- credit_available:
  - In ACTIVE, credit_available = credit_count > credit_withhold ? credit_count - credit_withhold : 0.
  - In INIT, credit_available = 0.
  - Purely combinational from registered count and the withhold input.
- push_ready = ACTIVE & !push_credit_stall & (credit_available != 0).
  - Does not depend on push_valid or pop_credit. A credit returned in cycle N is spendable in N+1.
- push_beat = push_valid & push_ready.
- tx_valid = push_beat, tx_data = push_data, same cycle (zero latency, combinational).
  - tx_data = push_data when tx_valid=0 (no hold requirement).
- credit_count next = credit_count - push_beat + pop_credit.
  - Simultaneous push_beat and pop_credit leaves the count unchanged.
  - If the result exceeds MaxCredit: count saturates at MaxCredit and credit_overflow sets. It clears only on reset.
  - Underflow cannot occur, because push_beat requires available>0.
- Withhold greater than or equal to count gives available=0. Reducing withhold reopens push_ready the same cycle.
- Reset mid-operation: all in-flight state is lost and no tx_valid is issued. The remote side is reset in the same domain by system contract.
- Data on push_data is not stored; the block holds no buffering in the default build.

Optional Feature:
- Macro: FIFO_CREDIT_SENDER_REG_OUT_EN.
- Defined:
  - tx_valid and tx_data come from flops loaded on push_beat, giving 1-cycle latency.
  - tx_valid resets to 0. tx_data flop loads only on push_beat and resets to 0.
  - Credit decrement still happens at push_beat time, so credit timing is identical.
- Undefined: combinational pass-through as above.

Decomposition:
- Package fifo_credit_pkg holds:
  - state enum {INIT, ACTIVE}.
  - A function computing CountWidth from MaxCredit.
  - A saturating add/sub helper.
- Sub-module fifo_credit_counter holds:
  - The counter register, INIT load with clamp, incr/decr, saturation and overflow flag.
  - The credit_available computation.
- Top level holds the handshake gating and the optional output register.

Test Plan:
- Reset, credit_initial=12, withhold=0, push_valid held high:
  - Exactly 12 beats with tx_valid=1 in cycles 1..12 after INIT.
  - Then push_ready=0 and credit_count=0.
- At count=0, pulse pop_credit in cycle N -> push_ready=1 in N+1, one beat, count back to 0.
- At count=5, push_beat and pop_credit in the same cycle -> count stays 5 and tx_valid=1.
- count=5, withhold=3 -> credit_available=2 and exactly 2 beats pass.
  - Then withhold=5 -> push_ready=0.
  - push_credit_stall=1 with credits available -> push_ready=0.
- At count=12, pulse pop_credit -> count stays 12 and credit_overflow=1 sticky.
  - Then assert rst_n=0 mid-stream -> all outputs 0 immediately, flag cleared.
  - After release, INIT reloads credit_initial.
- With FIFO_CREDIT_SENDER_REG_OUT_EN, push 0xA5 in cycle N -> tx_valid=1, tx_data=0xA5 in N+1; credit_count decremented at end of N.
